// File: rtl/avaliador_rgb_if.sv
// Sensor-side and verdict-side signals of the RGB evaluator.
// The sensor drives samples; the evaluator returns the registered verdict.
interface avaliador_rgb_if #(
   parameter int W = 8
);
   logic         presenca;
   logic         cor_valida;
   logic [W-1:0] cor_r;
   logic [W-1:0] cor_g;
   logic [W-1:0] cor_b;
   logic         rgb;
   logic         rgb_valido;
   logic         falha;

   modport master (
      output presenca, cor_valida, cor_r, cor_g, cor_b,
      input  rgb, rgb_valido, falha
   );

   modport slave (
      input  presenca, cor_valida, cor_r, cor_g, cor_b,
      output rgb, rgb_valido, falha
   );
endinterface

// File: rtl/avaliador_rgb.sv
// Color evaluator: settle, average N samples, compare with reference,
// emit one registered verdict pulse per presence event.
module avaliador_rgb #(
   parameter int W       = 8,
   parameter int N_LOG2  = 2,
   parameter int SETTLE  = 16,
   parameter int TIMEOUT = 1024,
   parameter int REF_R   = 200,
   parameter int REF_G   = 50,
   parameter int REF_B   = 50,
   parameter int TOL     = 10
) (
   input logic              clk,
   input logic              rst,
   avaliador_rgb_if.slave   bus
);
   localparam int N  = 1 << N_LOG2;
   localparam int AW = W + N_LOG2;
   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = N_LOG2 + 1;

   localparam logic [W-1:0] RR = W'(REF_R);
   localparam logic [W-1:0] RG = W'(REF_G);
   localparam logic [W-1:0] RB = W'(REF_B);
   localparam logic [W-1:0] TL = W'(TOL);

   typedef enum logic [2:0] {
      OCIOSO,
      ESPERA,
      AMOSTRANDO,
      DECIDE,
      CONCLUIDO
   } estado_t;

   estado_t estado_q, estado_d;
   logic [SW-1:0] set_q, set_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [CW-1:0] smp_q, smp_d;
   logic [AW-1:0] acc_r_q, acc_r_d;
   logic [AW-1:0] acc_g_q, acc_g_d;
   logic [AW-1:0] acc_b_q, acc_b_d;
   logic dvld_q, dvld_d;
   logic dpass_q, dpass_d;
   logic dfal_q, dfal_d;
   logic vld_q, vld_d;
   logic rgb_q, rgb_d;
   logic fal_q, fal_d;

   function automatic logic perto(
      input logic [W-1:0] a,
      input logic [W-1:0] b
   );
      logic [W-1:0] d;
      d = (a >= b) ? (a - b) : (b - a);
      return d <= TL;
   endfunction

   logic [W-1:0] avg_r, avg_g, avg_b;
   logic         ok;
   logic         cheio;

   assign avg_r = acc_r_q[AW-1:N_LOG2];
   assign avg_g = acc_g_q[AW-1:N_LOG2];
   assign avg_b = acc_b_q[AW-1:N_LOG2];
   assign cheio = (smp_q == CW'(N));
   assign ok    = perto(avg_r, RR) & perto(avg_g, RG) & perto(avg_b, RB);

   always_comb begin
      estado_d = estado_q;
      set_d    = set_q;
      tmo_d    = tmo_q;
      smp_d    = smp_q;
      acc_r_d  = acc_r_q;
      acc_g_d  = acc_g_q;
      acc_b_d  = acc_b_q;
      dvld_d   = 1'b0;
      dpass_d  = dpass_q;
      dfal_d   = dfal_q;
      vld_d    = dvld_q;
      rgb_d    = rgb_q;
      fal_d    = fal_q;
      // staged verdict reaches the outputs one cycle after DECIDE
      if (dvld_q) begin
         rgb_d = dpass_q;
         fal_d = dfal_q;
      end
      unique case (estado_q)
         OCIOSO: begin
            if (bus.presenca) begin
               estado_d = ESPERA;
               set_d    = '0;
               rgb_d    = 1'b0;
               fal_d    = 1'b0;
            end
         end
         ESPERA: begin
            if (!bus.presenca) begin
               estado_d = OCIOSO;
            end else if (set_q == SW'(SETTLE - 1)) begin
               estado_d = AMOSTRANDO;
               tmo_d    = '0;
               smp_d    = '0;
               acc_r_d  = '0;
               acc_g_d  = '0;
               acc_b_d  = '0;
            end else begin
               set_d = set_q + 1'b1;
            end
         end
         AMOSTRANDO: begin
            if (!bus.presenca) begin
               estado_d = OCIOSO;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (bus.cor_valida) begin
                  acc_r_d = acc_r_q + AW'(bus.cor_r);
                  acc_g_d = acc_g_q + AW'(bus.cor_g);
                  acc_b_d = acc_b_q + AW'(bus.cor_b);
                  smp_d   = smp_q + 1'b1;
               end
               if ((bus.cor_valida && smp_q == CW'(N - 1)) ||
                   tmo_q == TW'(TIMEOUT - 1)) begin
                  estado_d = DECIDE;
               end
            end
         end
         DECIDE: begin
            // fewer than N samples here means the timeout fired
            dvld_d   = 1'b1;
            dpass_d  = ok & cheio;
            dfal_d   = ~cheio;
            estado_d = CONCLUIDO;
         end
         CONCLUIDO: begin
            if (!bus.presenca) estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= OCIOSO;
         set_q    <= '0;
         tmo_q    <= '0;
         smp_q    <= '0;
         acc_r_q  <= '0;
         acc_g_q  <= '0;
         acc_b_q  <= '0;
         dvld_q   <= 1'b0;
         dpass_q  <= 1'b0;
         dfal_q   <= 1'b0;
         vld_q    <= 1'b0;
         rgb_q    <= 1'b0;
         fal_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         set_q    <= set_d;
         tmo_q    <= tmo_d;
         smp_q    <= smp_d;
         acc_r_q  <= acc_r_d;
         acc_g_q  <= acc_g_d;
         acc_b_q  <= acc_b_d;
         dvld_q   <= dvld_d;
         dpass_q  <= dpass_d;
         dfal_q   <= dfal_d;
         vld_q    <= vld_d;
         rgb_q    <= rgb_d;
         fal_q    <= fal_d;
      end
   end

   assign bus.rgb        = rgb_q;
   assign bus.rgb_valido = vld_q;
   assign bus.falha      = fal_q;
endmodule

// File: tb/tb_avaliador_rgb.sv
// Bench for avaliador_rgb: per-edge stimulus tables checked against
// a sample-window model of the verdict and its timing.
module tb_avaliador_rgb;
   localparam int W       = 8;
   localparam int N       = 4;
   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 1024;
   localparam int REF_R   = 200;
   localparam int REF_G   = 50;
   localparam int REF_B   = 50;
   localparam int TOL     = 10;
   localparam int MAXK    = 1100;

   logic clk;
   logic rst;
   int checks;
   int failures;

   int sv [MAXK];
   int sr [MAXK];
   int sg [MAXK];
   int sb [MAXK];

   avaliador_rgb_if #(.W(W)) bus ();

   avaliador_rgb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_stim;
      for (int i = 0; i < MAXK; i++) begin
         sv[i] = 0; sr[i] = 0; sg[i] = 0; sb[i] = 0;
      end
   endtask

   task automatic put(input int k, input int r, input int g, input int b);
      sv[k] = 1; sr[k] = r; sg[k] = g; sb[k] = b;
   endtask

   task automatic drive(input int k, input logic pres);
      @(negedge clk);
      bus.presenca   = pres;
      bus.cor_valida = (k < MAXK) ? sv[k][0] : 1'b0;
      bus.cor_r      = (k < MAXK) ? W'(sr[k]) : '0;
      bus.cor_g      = (k < MAXK) ? W'(sg[k]) : '0;
      bus.cor_b      = (k < MAXK) ? W'(sb[k]) : '0;
   endtask

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   // edge 0 is the first edge that sees presenca=1 while idle
   task automatic run_eval(input string nm, input int abort_k, input int hold);
      int ar, ag, ab, cnt, e, dec_k, exp_k, last;
      bit tmo, pass, exp_rgb, exp_f, aborted, pres, pulse;
      logic er, ef;
      ar = 0; ag = 0; ab = 0; cnt = 0; e = -1;
      for (int k = SETTLE + 1; k <= SETTLE + TIMEOUT; k++) begin
         if (sv[k] != 0 && cnt < N) begin
            ar += sr[k]; ag += sg[k]; ab += sb[k];
            cnt++;
            if (cnt == N) e = k;
         end
      end
      tmo   = (e < 0);
      dec_k = tmo ? SETTLE + TIMEOUT : e;
      exp_k = dec_k + 2;
      pass  = absd(ar / N, REF_R) <= TOL &&
              absd(ag / N, REF_G) <= TOL &&
              absd(ab / N, REF_B) <= TOL;
      exp_rgb = pass && !tmo;
      exp_f   = tmo;
      aborted = (abort_k >= 1) && (abort_k <= dec_k);
      last    = aborted ? abort_k + 2 : exp_k + hold;
      for (int k = 0; k <= last; k++) begin
         pres = (abort_k < 1) || (k < abort_k);
         drive(k, pres);
         @(posedge clk);
         #1;
         pulse = !aborted && (k == exp_k);
         checks++;
         if (bus.rgb_valido !== pulse) begin
            failures++;
            $display("FAIL %s k=%0d rgb_valido got=%b exp=%b",
                     nm, k, bus.rgb_valido, pulse);
         end
         er = (!aborted && k >= exp_k) ? exp_rgb : 1'b0;
         ef = (!aborted && k >= exp_k) ? exp_f : 1'b0;
         checks++;
         if (bus.rgb !== er || bus.falha !== ef) begin
            failures++;
            $display("FAIL %s k=%0d rgb/falha got=%b/%b exp=%b/%b",
                     nm, k, bus.rgb, bus.falha, er, ef);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(MAXK, 1'b0);
         @(posedge clk);
         #1;
         checks++;
         if (bus.rgb_valido !== 1'b0) begin
            failures++;
            $display("FAIL %s idle rgb_valido got=%b exp=0", nm, bus.rgb_valido);
         end
      end
      clear_stim();
   endtask

   task automatic good4(input int k0);
      for (int i = 0; i < N; i++) put(k0 + i, REF_R, REF_G, REF_B);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(MAXK, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.rgb, bus.rgb_valido, bus.falha} !== 3'b000) begin
         failures++;
         $display("FAIL reset outputs got=%b exp=000",
                  {bus.rgb, bus.rgb_valido, bus.falha});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.rgb, bus.rgb_valido, bus.falha} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset outputs got=%b exp=000",
                  {bus.rgb, bus.rgb_valido, bus.falha});
      end
   endtask

   task automatic test_nominal;
      good4(SETTLE + 1);
      run_eval("nominal", -1, 12);
      for (int i = 0; i < N; i++) put(SETTLE + 1 + i, 185, 50, 50);
      run_eval("fail_r185", -1, 4);
   endtask

   task automatic test_tolerance;
      put(17, 210, 50, 50); put(18, 210, 50, 50);
      put(19, 211, 50, 50); put(20, 211, 50, 50);
      run_eval("trunc_210", -1, 3);
      for (int i = 0; i < N; i++) put(17 + i, 211, 50, 50);
      run_eval("r211", -1, 3);
      for (int i = 0; i < N; i++) put(17 + i, 200, 40, 50);
      run_eval("g40", -1, 3);
      for (int i = 0; i < N; i++) put(17 + i, 190, 50, 60);
      run_eval("low_edge", -1, 3);
      for (int i = 0; i < N; i++) put(17 + i, 189, 50, 50);
      run_eval("r189", -1, 3);
      for (int i = 0; i < N; i++) put(20 + 3 * i, 200, 50, 61);
      run_eval("b61_gaps", -1, 3);
   endtask

   task automatic test_settle;
      for (int k = 0; k <= SETTLE; k++) put(k, 0, 0, 0);
      good4(SETTLE + 1);
      run_eval("settle", -1, 3);
   endtask

   task automatic test_timeout;
      put(30, REF_R, REF_G, REF_B);
      put(100, REF_R, REF_G, REF_B);
      run_eval("timeout", -1, 3);
      good4(SETTLE + TIMEOUT - 3);
      run_eval("last_slot", -1, 3);
      good4(SETTLE + TIMEOUT - 2);
      run_eval("too_late", -1, 3);
   endtask

   task automatic test_abort;
      put(17, REF_R, REF_G, REF_B);
      put(18, REF_R, REF_G, REF_B);
      run_eval("abort_2smp", 25, 0);
      good4(SETTLE + 1);
      run_eval("rearm", -1, 3);
      good4(SETTLE + 1);
      run_eval("abort_vs_nth", SETTLE + 4, 0);
      good4(SETTLE + 1);
      run_eval("abort_settle", 5, 0);
      good4(SETTLE + 1);
      run_eval("drop_in_decide", SETTLE + 5, 3);
   endtask

   task automatic test_reset_mid;
      good4(SETTLE + 1);
      for (int k = 0; k < 25; k++) begin
         drive(k, 1'b1);
         @(posedge clk);
      end
      #1;
      checks++;
      if (bus.rgb !== 1'b1) begin
         failures++;
         $display("FAIL hold_before_rst rgb got=%b exp=1", bus.rgb);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.rgb, bus.rgb_valido, bus.falha} !== 3'b000) begin
         failures++;
         $display("FAIL rst_concluido outputs got=%b exp=000",
                  {bus.rgb, bus.rgb_valido, bus.falha});
      end
      drive(MAXK, 1'b0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < SETTLE + 4; k++) begin
         drive(k, 1'b1);
         @(posedge clk);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({bus.rgb, bus.rgb_valido, bus.falha} !== 3'b000) begin
         failures++;
         $display("FAIL rst_amostrando outputs got=%b exp=000",
                  {bus.rgb, bus.rgb_valido, bus.falha});
      end
      bus.presenca = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = SETTLE + 4; k < SETTLE + 12; k++) begin
         drive(k, 1'b0);
         @(posedge clk);
         #1;
         checks++;
         if (bus.rgb_valido !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_pulse k=%0d rgb_valido got=%b exp=0",
                     k, bus.rgb_valido);
         end
      end
      clear_stim();
      good4(SETTLE + 1);
      run_eval("after_rst", -1, 3);
   endtask

   task automatic test_random;
      int ab;
      for (int it = 0; it < 16; it++) begin
         for (int k = 0; k < SETTLE + 60; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               put(k, REF_R + int'($urandom_range(0, 30)) - 15,
                      REF_G + int'($urandom_range(0, 30)) - 15,
                      REF_B + int'($urandom_range(0, 30)) - 15);
            end
         end
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SETTLE + 12)) : -1;
         run_eval("random", ab, 2);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.presenca   = 1'b0;
      bus.cor_valida = 1'b0;
      bus.cor_r      = '0;
      bus.cor_g      = '0;
      bus.cor_b      = '0;
      clear_stim();
      test_reset();
      test_nominal();
      test_tolerance();
      test_settle();
      test_abort();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
